// File: rtl/sobel_window_gen.sv
// Zero-padded 3x3 raster window generator feeding the Sobel kernel; window k leaves one cycle after pixel k+W+1 is accepted.
// No backpressure: every valid pixel is taken, pixels arriving during the self-flush are dropped and flagged on overrun.
module sobel_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic                    pixel_in_valid,
    output logic [9*DATA_WIDTH-1:0] window_out,
    output logic                    window_valid,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(IMG_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t state;

    logic [IDX_W-1:0] in_idx;
    logic [COL_W-1:0] in_col;
    logic [IDX_W-1:0] out_idx;
    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;

    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] hist [3][2];

    logic                    accept;
    logic                    step;
    logic                    emit;
    logic [DATA_WIDTH-1:0]   new_col [3];
    logic                    row_ok [3];
    logic                    col_ok [3];
    logic [DATA_WIDTH-1:0]   raw;
    logic [9*DATA_WIDTH-1:0] win_next;

    assign accept = pixel_in_valid && (state != FLUSH);
    assign step   = accept || (state == FLUSH);
    assign emit   = (state == RUN && pixel_in_valid) || (state == FLUSH);

    // During flush the pseudo-pixels lie below the frame, so the bottom row is fed zeros.
    always_comb begin
        new_col[0] = lb1[in_col];
        new_col[1] = lb0[in_col];
        new_col[2] = (state == FLUSH) ? '0 : pixel_in;
    end

    // Padding by masking: wrapped columns and stale line-buffer rows never escape.
    always_comb begin
        row_ok[0] = (out_row != '0);
        row_ok[1] = 1'b1;
        row_ok[2] = (out_row != ROW_LAST);
        col_ok[0] = (out_col != '0);
        col_ok[1] = 1'b1;
        col_ok[2] = (out_col != COL_LAST);
        win_next  = '0;
        raw       = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (c == 2) raw = new_col[r];
                else        raw = hist[r][c];
                if (row_ok[r] && col_ok[c])
                    win_next[(3*r+c)*DATA_WIDTH +: DATA_WIDTH] = raw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[in_col] <= lb0[in_col];
            lb0[in_col] <= pixel_in;
        end
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                hist[r][0] <= hist[r][1];
                hist[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_idx       <= '0;
            in_col       <= '0;
            out_idx      <= '0;
            out_col      <= '0;
            out_row      <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            window_valid <= emit;
            frame_done   <= 1'b0;
            if (emit) begin
                window_out <= win_next;
                out_idx    <= out_idx + 1'b1;
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
            if (step)
                in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
            if (accept)
                in_idx <= in_idx + 1'b1;

            case (state)
                IDLE:  if (pixel_in_valid) state <= FILL;
                FILL:  if (pixel_in_valid && in_idx == FILL_LAST) state <= RUN;
                RUN:   if (pixel_in_valid && in_idx == LAST_IDX) state <= FLUSH;
                FLUSH: begin
                    if (pixel_in_valid)
                        overrun <= 1'b1;
                    if (out_idx == LAST_IDX) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        in_idx     <= '0;
                        in_col     <= '0;
                        out_idx    <= '0;
                        out_col    <= '0;
                        out_row    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x3 frame; windows are scoreboarded against a zero-padded 3x3 model.
module tb_sobel_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   pixel_in;
    logic            pixel_in_valid;
    logic [9*DW-1:0] window_out;
    logic            window_valid;
    logic            frame_done;
    logic            overrun;

    sobel_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .window_out     (window_out),
        .window_valid   (window_valid),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic            last;
    } exp_t;

    exp_t            sb [$];
    logic [9*DW-1:0] cap [$];
    int              cap_cyc [$];
    int              acc_cyc [$];
    int              done_cyc;
    int              done_cnt;
    int              last_acc;
    logic [DW-1:0]   frame [N];

    function automatic void check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [9*DW-1:0] model(input int k);
        logic [9*DW-1:0] w;
        int rr, cc;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                rr = k / W + r - 1;
                cc = k % W + c - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    w[(3*r+c)*DW +: DW] = frame[rr*W+cc];
            end
        end
        return w;
    endfunction

    function automatic logic [9*DW-1:0] w9(input int a, b, c, d, e, f, g, h, i);
        return {i[7:0], h[7:0], g[7:0], f[7:0], e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    always @(negedge clk) begin
        if (window_valid) begin
            cap.push_back(window_out);
            cap_cyc.push_back(cyc);
            if (frame_done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            check("window_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("window_value", window_out, e.win);
                check("frame_done_flag", frame_done, e.last);
            end
        end
    end

    // mode 0: back-to-back, 1: alternating idle cycles, 2: random gaps; junk pixels are driven into the flush.
    task automatic run_frame(input int mode, input int npix, input int junk);
        int last_k;
        exp_t e;
        last_k = (npix == N) ? N - 1 : npix - W - 2;
        for (int k = 0; k <= last_k; k++) begin
            e.win  = model(k);
            e.last = (k == N - 1);
            sb.push_back(e);
        end
        cap.delete();
        cap_cyc.delete();
        acc_cyc.delete();
        done_cnt = 0;
        for (int i = 0; i < npix; i++) begin
            if (mode == 2) begin
                while ($urandom_range(0, 2) == 0) begin
                    @(negedge clk);
                    pixel_in_valid = 1'b0;
                end
            end
            @(negedge clk);
            pixel_in       = frame[i];
            pixel_in_valid = 1'b1;
            acc_cyc.push_back(cyc);
            if (mode == 1) begin
                @(negedge clk);
                pixel_in_valid = 1'b0;
            end
        end
        last_acc = acc_cyc[npix-1];
        for (int j = 0; j < junk; j++) begin
            @(negedge clk);
            pixel_in       = 8'hEE;
            pixel_in_valid = 1'b1;
        end
        @(negedge clk);
        pixel_in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    initial begin
        rst            = 1'b1;
        pixel_in       = '0;
        pixel_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_window_valid", window_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_window_out", window_out, 0);
        rst = 1'b0;

        // Back-to-back frame with pixel values i+1.
        for (int i = 0; i < N; i++) frame[i] = DW'(i + 1);
        run_frame(0, N, 0);
        drain("b2b");
        check("b2b_count", cap.size(), N);
        check("b2b_first", cap[0], w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("b2b_k5", cap[5], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        check("b2b_last", cap[N-1], w9(7, 8, 0, 11, 12, 0, 0, 0, 0));
        check("b2b_first_latency", cap_cyc[0] - acc_cyc[W+1], 1);
        check("b2b_no_gaps", cap_cyc[N-1] - cap_cyc[0], N - 1);
        check("b2b_done_latency", done_cyc - last_acc, W + 2);
        check("b2b_done_count", done_cnt, 1);

        // Same frame with pixel_in_valid toggling.
        run_frame(1, N, 0);
        drain("toggle");
        check("toggle_count", cap.size(), N);
        check("toggle_k3_right_edge", cap[3], w9(0, 0, 0, 3, 4, 0, 7, 8, 0));
        check("toggle_k4_left_edge", cap[4], w9(0, 1, 2, 0, 5, 6, 0, 9, 10));
        check("toggle_run_spacing", cap_cyc[1] - cap_cyc[0], 2);
        check("toggle_flush_consecutive", cap_cyc[N-1] - cap_cyc[N-1-W], W);
        check("toggle_done_latency", done_cyc - last_acc, W + 2);
        check("toggle_overrun_clear", overrun, 0);

        // Pixels pushed into the flush are dropped and flagged.
        run_frame(0, N, 3);
        drain("ovr");
        check("ovr_count", cap.size(), N);
        check("ovr_done_count", done_cnt, 1);
        check("ovr_done_latency", done_cyc - last_acc, W + 2);
        check("ovr_sticky", overrun, 1);

        // Next frame right after frame_done, random data and random gaps.
        for (int i = 0; i < N; i++) frame[i] = DW'($urandom_range(0, 255));
        run_frame(2, N, 0);
        drain("rand");
        check("rand_count", cap.size(), N);
        check("rand_done_count", done_cnt, 1);
        check("rand_done_latency", done_cyc - last_acc, W + 2);
        check("rand_overrun_held", overrun, 1);

        // Reset mid-RUN after pixel i=7.
        for (int i = 0; i < N; i++) frame[i] = DW'(200 + i);
        run_frame(0, 8, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_window_valid", window_valid, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_windows_seen", cap.size(), 3);
        rst = 1'b0;
        for (int i = 0; i < N; i++) frame[i] = DW'(101 + i);
        run_frame(0, N, 0);
        drain("fresh");
        check("fresh_count", cap.size(), N);
        check("fresh_first", cap[0], w9(0, 0, 0, 0, 101, 102, 0, 105, 106));
        check("fresh_done_count", done_cnt, 1);

        repeat (3) @(negedge clk);
        check("idle_quiet", window_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
